// File: rtl/cascade_mod_counter_pkg.sv
// Shared constants and helpers for the cascaded modulo counter: digit width,
// the per-digit modulus extraction and load-value saturation.
package cascade_mod_counter_pkg;

    localparam int DIG_W    = 4;
    localparam int MAX_NDIG = 8;

    typedef logic [DIG_W-1:0] digit_t;

    // The modulus vector is passed in its widest form so one function serves every NDIG.
    function automatic digit_t digit_mod(input logic [DIG_W*MAX_NDIG-1:0] mod_vec,
                                         input int idx);
        return mod_vec[idx*DIG_W +: DIG_W];
    endfunction

    function automatic digit_t sat_load(input digit_t value, input digit_t modulus);
        return (value >= modulus) ? digit_t'(modulus - 4'd1) : value;
    endfunction

    function automatic logic mod_legal(input digit_t modulus);
        return (modulus >= 4'd2) && (modulus <= 4'd10);
    endfunction

endpackage

// File: rtl/mod_digit.sv
// One modulo-N digit of the cascade: steps up or down on step_in, saturating
// parallel load, and a combinational wrap_out that feeds the next digit's step_in.
module mod_digit
    import cascade_mod_counter_pkg::*;
(
    input  logic   clk,
    input  logic   clr,
    input  logic   step_in,
    input  logic   dn,
    input  logic   load,
    input  digit_t din,
    input  digit_t modulus,
    output digit_t q,
    output logic   wrap_out
);

    digit_t q_d, q_q;
    digit_t last;
    logic   at_end;

    always_comb begin
        last     = digit_t'(modulus - 4'd1);
        at_end   = dn ? (q_q == '0) : (q_q == last);
        wrap_out = step_in & ~load & at_end;
        q_d      = q_q;
        if (load) begin
            q_d = sat_load(din, modulus);
        end else if (step_in) begin
            if (at_end) begin
                q_d = dn ? last : '0;
            end else begin
                q_d = dn ? digit_t'(q_q - 4'd1) : digit_t'(q_q + 4'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/cascade_mod_counter.sv
// Cascaded modulo counter built from NDIG mod_digit instances (default 00..59).
// Define CASCADE_MOD_COUNTER_DOWN_EN to add the dn port and down-counting.
module cascade_mod_counter
    import cascade_mod_counter_pkg::*;
#(
    parameter int                      NDIG    = 2,
    parameter logic [DIG_W*NDIG-1:0]   MOD_VEC = {4'd6, 4'd10}
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    load,
    input  logic [DIG_W*NDIG-1:0]   din,
`ifdef CASCADE_MOD_COUNTER_DOWN_EN
    input  logic                    dn,
`endif
    output logic [DIG_W*NDIG-1:0]   q,
    output logic                    cout,
    output logic                    tc
);

    localparam logic [DIG_W*MAX_NDIG-1:0] MOD_EXT = (DIG_W*MAX_NDIG)'(MOD_VEC);

    if ((NDIG < 1) || (NDIG > MAX_NDIG)) begin : g_bad_ndig
        $error("cascade_mod_counter: NDIG=%0d outside 1..%0d", NDIG, MAX_NDIG);
    end

    logic                  dn_w;
    logic [NDIG:0]         step;
    logic [DIG_W*NDIG-1:0] q_w;
    logic                  cout_d, cout_q;
    logic                  all_max;

`ifdef CASCADE_MOD_COUNTER_DOWN_EN
    assign dn_w = dn;
`else
    assign dn_w = 1'b0;
`endif

    // Load wins over en, so a loading edge never steps or carries.
    assign step[0] = en & ~load;

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        localparam digit_t MOD_G = digit_mod(MOD_EXT, g);

        if (!mod_legal(MOD_G)) begin : g_bad_mod
            $error("cascade_mod_counter: digit %0d modulus %0d outside 2..10", g, MOD_G);
        end

        mod_digit u_digit (
            .clk      (clk),
            .clr      (clr),
            .step_in  (step[g]),
            .dn       (dn_w),
            .load     (load),
            .din      (din[g*DIG_W +: DIG_W]),
            .modulus  (MOD_G),
            .q        (q_w[g*DIG_W +: DIG_W]),
            .wrap_out (step[g+1])
        );
    end

    // The top digit wrapping means the whole chain wrapped on this edge.
    always_comb begin
        cout_d = step[NDIG];
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cout_q <= 1'b0;
        end else begin
            cout_q <= cout_d;
        end
    end

`ifdef CASCADE_MOD_COUNTER_DOWN_EN
    logic all_zero;

    always_comb begin
        all_max  = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (q_w[i*DIG_W +: DIG_W] != digit_t'(digit_mod(MOD_EXT, i) - 4'd1)) begin
                all_max = 1'b0;
            end
            if (q_w[i*DIG_W +: DIG_W] != '0) begin
                all_zero = 1'b0;
            end
        end
        tc = dn_w ? all_zero : all_max;
    end
`else
    always_comb begin
        all_max = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (q_w[i*DIG_W +: DIG_W] != digit_t'(digit_mod(MOD_EXT, i) - 4'd1)) begin
                all_max = 1'b0;
            end
        end
        tc = all_max;
    end
`endif

    assign q    = q_w;
    assign cout = cout_q;

endmodule

// File: tb/tb_cascade_mod_counter.sv
// Self-checking bench for cascade_mod_counter at default parameters (00..59);
// exercises the down-count path too when CASCADE_MOD_COUNTER_DOWN_EN is defined.
module tb_cascade_mod_counter;

    localparam int              NDIG    = 2;
    localparam int              DW      = 4 * NDIG;
    localparam int              W       = DW + 2;
    localparam logic [DW-1:0]   MOD_VEC = {4'd6, 4'd10};

    logic          clk;
    logic          clr;
    logic          en;
    logic          load;
    logic [DW-1:0] din;
    logic          dn;
    logic [DW-1:0] q;
    logic          cout;
    logic          tc;

    int checks;
    int errors;

    logic [W-1:0] exp_q[$];

    cascade_mod_counter #(
        .NDIG    (NDIG),
        .MOD_VEC (MOD_VEC)
    ) dut (
        .clk  (clk),
        .clr  (clr),
        .en   (en),
        .load (load),
        .din  (din),
`ifdef CASCADE_MOD_COUNTER_DOWN_EN
        .dn   (dn),
`endif
        .q    (q),
        .cout (cout),
        .tc   (tc)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (mixed-radix integer) ----------------
    int md[NDIG];
    bit m_cout;

    function automatic int tb_mod(input int i);
        logic [DW-1:0] mv;
        mv = MOD_VEC;
        return int'(mv[i*4 +: 4]);
    endfunction

    function automatic int total_states();
        int t;
        t = 1;
        for (int i = 0; i < NDIG; i++) t = t * tb_mod(i);
        return t;
    endfunction

    function automatic int model_val();
        int v;
        v = 0;
        for (int i = NDIG - 1; i >= 0; i--) v = v * tb_mod(i) + md[i];
        return v;
    endfunction

    function automatic void model_set(input int value);
        int v;
        v = value;
        for (int i = 0; i < NDIG; i++) begin
            md[i] = v % tb_mod(i);
            v     = v / tb_mod(i);
        end
    endfunction

    function automatic logic [DW-1:0] model_q();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < NDIG; i++) r[i*4 +: 4] = 4'(md[i]);
        return r;
    endfunction

    function automatic logic model_tc(input logic dir);
        return dir ? (model_val() == 0) : (model_val() == total_states() - 1);
    endfunction

    function automatic logic [W-1:0] model_update(input logic e, input logic l,
                                                  input logic [DW-1:0] d, input logic dir);
        int v;
        int dd;
        if (l) begin
            for (int i = 0; i < NDIG; i++) begin
                dd    = int'(d[i*4 +: 4]);
                md[i] = (dd >= tb_mod(i)) ? tb_mod(i) - 1 : dd;
            end
            m_cout = 1'b0;
        end else if (e) begin
            v = model_val();
            if (dir) begin
                m_cout = (v == 0);
                v      = (v + total_states() - 1) % total_states();
            end else begin
                m_cout = (v == total_states() - 1);
                v      = (v + 1) % total_states();
            end
            model_set(v);
        end else begin
            m_cout = 1'b0;
        end
        return {model_q(), m_cout, model_tc(dir)};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NDIG; i++) md[i] = 0;
        m_cout = 1'b0;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got q=%h cout=%b tc=%b, expected q=%h cout=%b tc=%b",
                     name, act[W-1:2], act[1], act[0], exp[W-1:2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle from a negedge; compare #1 after the following posedge.
    task automatic drive(input string name, input logic e, input logic l,
                         input logic [DW-1:0] d, input logic dir,
                         input bit use_exp, input logic [W-1:0] exp);
        logic [W-1:0] m;
        logic [W-1:0] got;
        en   = e;
        load = l;
        din  = d;
        dn   = dir;
        m    = model_update(e, l, d, dir);
        exp_q.push_back(use_exp ? exp : m);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check(name, {q, cout, tc}, got);
        @(negedge clk);
    endtask

    task automatic drive_model(input string name, input logic e, input logic l,
                               input logic [DW-1:0] d, input logic dir);
        drive(name, e, l, d, dir, 1'b0, '0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string         name;
        logic          en;
        logic          load;
        logic [DW-1:0] din;
        logic          dn;
        logic [DW-1:0] eq;
        logic          ecout;
        logic          etc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input string n, input logic e, input logic l,
                                    input logic [DW-1:0] d, input logic dir,
                                    input logic [DW-1:0] eq, input logic ec, input logic et);
        vec_t v;
        v.name = n; v.en = e; v.load = l; v.din = d; v.dn = dir;
        v.eq = eq; v.ecout = ec; v.etc = et;
        vecs.push_back(v);
    endfunction

    // ---------------- test ----------------
    initial begin
        checks = 0;
        errors = 0;
        clr  = 1'b0;
        en   = 1'b0;
        load = 1'b0;
        din  = '0;
        dn   = 1'b0;
        model_reset();

        add_vec("load_37",        0, 1, 8'h37, 0, 8'h37, 0, 0);
        add_vec("load_59",        0, 1, 8'h59, 0, 8'h59, 0, 1);
        add_vec("wrap_59_00",     1, 0, 8'h00, 0, 8'h00, 1, 0);
        add_vec("cout_drops",     0, 0, 8'h00, 0, 8'h00, 0, 0);
        add_vec("load_sat_9C",    0, 1, 8'h9C, 0, 8'h59, 0, 1);
        add_vec("load_over_en",   1, 1, 8'h12, 0, 8'h12, 0, 0);
        add_vec("load_sat_A5",    0, 1, 8'hA5, 0, 8'h55, 0, 0);
        add_vec("load_09",        0, 1, 8'h09, 0, 8'h09, 0, 0);
        add_vec("carry_09_10",    1, 0, 8'h00, 0, 8'h10, 0, 0);
        add_vec("load_58",        0, 1, 8'h58, 0, 8'h58, 0, 0);
        add_vec("hold_58",        0, 0, 8'h00, 0, 8'h58, 0, 0);
        add_vec("step_58_59",     1, 0, 8'h00, 0, 8'h59, 0, 1);
        add_vec("hold_59",        0, 0, 8'h00, 0, 8'h59, 0, 1);
        add_vec("wrap_after_hold",1, 0, 8'h00, 0, 8'h00, 1, 0);
        add_vec("idle_after_wrap",0, 0, 8'h00, 0, 8'h00, 0, 0);

        // Reset state, before any clock edge.
        #1;
        check("reset_state", {q, cout, tc}, {8'h00, 1'b0, 1'b0});
        @(negedge clk);
        clr = 1'b1;

        // Sixty enabled cycles walk 00..59 and wrap back to 00 with one cout pulse.
        for (int i = 0; i < 60; i++) begin
            drive_model($sformatf("count_%0d", i), 1'b1, 1'b0, '0, 1'b0);
        end
        check("count_end_q", {q, cout, tc}, {8'h00, 1'b1, 1'b0});
        drive_model("count_pulse_off", 1'b0, 1'b0, '0, 1'b0);

        foreach (vecs[k]) begin
            drive(vecs[k].name, vecs[k].en, vecs[k].load, vecs[k].din, vecs[k].dn,
                  1'b1, {vecs[k].eq, vecs[k].ecout, vecs[k].etc});
        end

        // Asynchronous clear between edges at q=42.
        drive_model("load_42", 1'b0, 1'b1, 8'h42, 1'b0);
        #2 clr = 1'b0;
        #1;
        check("async_clr_42", {q, cout, tc}, {8'h00, 1'b0, 1'b0});
        model_reset();
        @(negedge clk);
        clr = 1'b1;
        drive_model("after_clr_idle", 1'b0, 1'b0, '0, 1'b0);

        // Clear while the wrap pulse is high kills the pulse.
        drive_model("load_59_b", 1'b0, 1'b1, 8'h59, 1'b0);
        drive_model("wrap_pulse", 1'b1, 1'b0, '0, 1'b0);
        #2 clr = 1'b0;
        #1;
        check("clr_kills_pulse", {q, cout, tc}, {8'h00, 1'b0, 1'b0});
        model_reset();
        @(negedge clk);
        clr = 1'b1;
        drive_model("count_after_release", 1'b1, 1'b0, '0, 1'b0);

`ifdef CASCADE_MOD_COUNTER_DOWN_EN
        drive("dn_load_01",    1'b0, 1'b1, 8'h01, 1'b0, 1'b1, {8'h01, 1'b0, 1'b0});
        drive("dn_01_00",      1'b1, 1'b0, 8'h00, 1'b1, 1'b1, {8'h00, 1'b0, 1'b1});
        drive("dn_00_59",      1'b1, 1'b0, 8'h00, 1'b1, 1'b1, {8'h59, 1'b1, 1'b0});
        drive("up_flip_59_00", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, {8'h00, 1'b1, 1'b0});
        drive("dn_borrow_10",  1'b0, 1'b1, 8'h10, 1'b1, 1'b1, {8'h10, 1'b0, 1'b0});
        drive("dn_10_09",      1'b1, 1'b0, 8'h00, 1'b1, 1'b1, {8'h09, 1'b0, 1'b0});
`endif

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            logic          r_en;
            logic          r_ld;
            logic [DW-1:0] r_din;
            logic          r_dn;
            r_en  = ($urandom_range(0, 3) != 0);
            r_ld  = ($urandom_range(0, 9) == 0);
            r_din = DW'($urandom_range(0, 255));
`ifdef CASCADE_MOD_COUNTER_DOWN_EN
            r_dn  = ($urandom_range(0, 1) == 1);
`else
            r_dn  = 1'b0;
`endif
            drive_model($sformatf("rand_%0d", i), r_en, r_ld, r_din, r_dn);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cascade_mod_counter.md
CASCADE_MOD_COUNTER -- requirements
Module: cascade_mod_counter

Interface
REQ-001 SHALL have parameter NDIG, default 2: number of cascaded 4-bit digits, legal range 1..8.
REQ-002 SHALL have parameter MOD_VEC [4*NDIG-1:0], default {4'd6,4'd10}: packed per-digit modulus, digit 0 in LSBs, each legal 2..10 (default counts 00..59).
REQ-003 SHALL have port clk, input, 1 bit: clock, rising edge active.
REQ-004 SHALL have port clr, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port en, input, 1 bit: count enable.
REQ-006 SHALL have port load, input, 1 bit: synchronous parallel load.
REQ-007 SHALL have port din, input, 4*NDIG bits: load value, packed per digit.
REQ-008 SHALL have port dn, input, 1 bit: count direction, 1 = down; present only when CASCADE_MOD_COUNTER_DOWN_EN is defined.
REQ-009 SHALL have port q, output, 4*NDIG bits: count value, packed per digit.
REQ-010 SHALL have port cout, output, 1 bit: registered chain wrap pulse.
REQ-011 SHALL have port tc, output, 1 bit: terminal-count flag, combinational from q (and dn).

Function
REQ-012 Digit i SHALL count 0..MOD_VEC[i]-1; up-step from MOD_VEC[i]-1 SHALL wrap to 0 and carry into digit i+1 in the same edge.
REQ-013 Digit 0 SHALL step on every rising clk edge with en=1 and load=0; digit i>0 SHALL step only when all lower digits wrap on that edge.
REQ-014 tc SHALL be 1 when every digit equals MOD_VEC[i]-1 (up) or every digit equals 0 (down), independent of en.
REQ-015 On an edge with en=1, load=0 and tc=1, the whole chain SHALL wrap and cout SHALL be 1 for exactly the following clock cycle, else 0 (single pulse, never a toggle).
REQ-016 load=1 SHALL take priority over en: q <= din on the edge, no carry, cout <= 0.
REQ-017 A loaded digit value >= MOD_VEC[i] SHALL be replaced by MOD_VEC[i]-1 (saturate, never hold an illegal state).
REQ-018 en=0 and load=0 SHALL hold q; cout SHALL return to 0 after one cycle.
REQ-019 Count latency: q SHALL reflect each step at the clk edge where en is sampled; no pipeline delay.

Reset
REQ-020 clr=0 SHALL immediately force q=0 and cout=0, regardless of clk, en or load.
REQ-021 Release of clr SHALL be honoured on the next rising edge; an en=1 sampled on that edge SHALL count normally.
REQ-022 Reset mid-wrap SHALL suppress any pending cout pulse.

Configuration
REQ-023 With CASCADE_MOD_COUNTER_DOWN_EN defined: dn=1 SHALL step down, digit 0 wrapping to MOD_VEC[i]-1 with borrow into digit i+1; cout SHALL pulse on whole-chain wrap from all-zero to all-max.
REQ-024 Without CASCADE_MOD_COUNTER_DOWN_EN: no dn port; the counter SHALL be up-only and tc SHALL use only the all-max condition.
REQ-025 dn change on an enabled edge SHALL take effect on that same edge.

Structure
REQ-026 Package cascade_mod_counter_pkg SHALL hold DIG_W=4, MAX_NDIG=8, the function extracting digit modulus from MOD_VEC, and the function saturating a load value.
REQ-027 Sub-module mod_digit SHALL implement one digit (step_in, dn, load, din, modulus -> q, wrap_out); top SHALL instantiate NDIG copies in a generate loop.
REQ-028 An illegal NDIG or any modulus outside 2..10 SHALL cause an elaboration-time error.

Verification
REQ-029 Defaults, clr pulse then en=1 for 60 cycles -> q steps 00..59, then 00; cout=1 only in the cycle after the 59->00 edge.
REQ-030 q=37, load=1, din=0x59 -> q=59 with cout=0; next edge with en=1 -> q=00, cout pulse.
REQ-031 load with din=0x9C -> q=59 (digit1 9->5, digit0 12->9 saturated).
REQ-032 en toggled 1,0,1 at q=58 -> q=58,58... holds while en=0, then 59, 00; tc=1 only while q=59.
REQ-033 clr asserted between edges at q=42 -> q=00 immediately, cout=0, no stale pulse after release.
REQ-034 DOWN_EN build, dn=1 from q=01 -> 00 then 59 with cout pulse; dn flipped to 0 at q=59 -> next edge 00 with cout pulse.
